usb_spi_target_regs: RTL and testbench
======================================

// Module: usb_spi_target_regs
// PURPOSE
// SPI target (responder) for the SPI initiator side of the USB-SPI bridge endpoint. Lets an external
// SPI master read and write an 8-bit register space inside the design, such as the pin value/enable
// test registers. Oversamples SPI mode 0 (CPOL=0, CPHA=0, MSB first) in the 48 MHz clk domain.
// Drives a one-cycle-strobe register bus to a separate register file.
// PARAMETERS
// SYNC_STAGES  2      flop stages on spi_cs_b/spi_sck/spi_mosi before edge detect (>=2)
// ID_BYTE      8'hA5  byte shifted out on MISO during the command byte (presence check)
// PORTS
// clk          in   1  48 MHz system clock; the only clock
// reset        in   1  synchronous, active-high
// spi_cs_b     in   1  chip select, active low, asynchronous to clk
// spi_sck      in   1  SPI clock, asynchronous; f_sck <= f_clk/8, each phase >= 4 clk
// spi_mosi     in   1  data from master
// spi_miso     out  1  data to master
// spi_miso_oe  out  1  MISO output enable (pad tristate control)
// bus_addr     out  7  register address
// bus_wdata    out  8  write data
// bus_we       out  1  write strobe, 1 clk
// bus_re       out  1  read strobe, 1 clk
// bus_rdata    in   8  read data, valid exactly 1 clk after bus_re
// frame_abort  out  1  1-clk pulse: CS deasserted mid-byte
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; bit_cnt=0; addr=0; armed=0. armed sets once synced cs_b is 1.
//   A frame starts only on a synced cs_b 1->0 while armed. CS held low across reset is ignored.
// - Sync: three inputs pass through SYNC_STAGES flops. sck_rise/sck_fall and cs_fall/cs_rise come from
//   the last stage vs. one extra registered copy. All further timing is relative to these pulses.
// - Frame: byte0 = command {rw, addr[6:0]}; rw=1 write, rw=0 read. Data bytes follow. addr
//   auto-increments after each data byte, 7-bit, wraps 0x7F->0x00.
// - Bit engine: sck_rise shifts mosi_s into rx_shift LSB and increments bit_cnt (3 bits). On the 8th
//   rise (bit_cnt 7->0) byte_done pulses in the same cycle. sck_fall shifts tx_shift left by one.
//   On the first sck_fall after byte_done, tx_shift loads tx_hold instead of shifting.
//   spi_miso = tx_shift[7].
// - FSM IDLE->CMD on cs_fall: tx_shift<=ID_BYTE (MSB on MISO before the first rise), bit_cnt<=0,
//   spi_miso_oe<=1.
// - CMD, byte_done: addr<=rx[6:0]. rw=1 -> WR. rw=0 -> RD, issue bus_re (bus_addr=rx[6:0]) next clk.
// - WR, byte_done: next clk bus_we=1, bus_addr=addr, bus_wdata=byte; addr<=addr+1.
// - RD: bus_rdata is captured into tx_hold 1 clk after bus_re. At each byte_done, bus_re is issued
//   for addr+1, then addr<=addr+1 (prefetch). MISO byte n (n>=1) = reg[A+n-1]. One surplus read
//   occurs at frame end; the register space must have side-effect-free reads.
// - Fill bytes: tx_hold=8'h00 in CMD-to-WR and during WR (MISO shifts zeros).
// - Latency: from sck_rise detect of the last bit, bus_we/bus_re assert exactly 2 clk later.
//   sck_rise -> byte_done is registered; byte_done -> strobe is 1 clk.
// - cs_rise in any state -> IDLE next clk; spi_miso_oe<=0, spi_miso<=0. If bit_cnt!=0:
//   frame_abort pulses 1 clk and the partial byte is discarded (no strobe). A byte completed on the
//   same clk as cs_rise is still committed.
// - Simultaneous events: sck edges while IDLE are ignored. bus_we and bus_re are never both 1.
//   Reset has priority over every event.
// STRUCTURE
// - Include usb_spi_target_defs.vh: state encodings IDLE/CMD/WR/RD, CMD_RW_BIT=7, ADDR_W=7.
// - Sub-module spi_input_sync: SYNC_STAGES synchronizer + edge detect for cs_b/sck/mosi;
//   outputs cs_s, mosi_s, sck_rise, sck_fall, cs_fall, cs_rise.
// - Top level holds bit engine, FSM, address counter, bus strobes. Target size ~200 lines.
// TESTING (bench: SPI master BFM at f_clk/8, reg model rdata = addr ^ 8'hF0)
// 1 Write: CS low, 0x85,0x12,0x34, CS high -> bus_we (0x05,0x12),(0x06,0x34); no abort;
//   MISO = A5,00,00.
// 2 Read: CS low, 0x03 + 2 dummies -> bus_re @0x03,0x04,0x05; MISO = A5,F3,F4; spi_miso_oe high
//   only while CS low.
// 3 Wrap: 0xFF,0x11,0x22,0x33 -> bus_we at 0x7F,0x00,0x01.
// 4 Abort: 0x81 then CS high after 5 bits -> no bus_we, one frame_abort pulse;
//   next frame 0x81,0x55 writes (0x01,0x55).
// 5 Reset mid-RD with CS held low -> all outputs 0 next clk; later edges ignored until CS high then
//   low; next frame OK.
// 6 Command only: 0x10 then CS high -> one bus_re @0x10, no bus_we, no frame_abort.

Source files
------------

// File: rtl/usb_spi_target_regs_pkg.sv
// Shared definitions for the SPI target register-bus bridge: FSM encodings,
// command-byte layout and address width.
package usb_spi_target_regs_pkg;

  localparam int ADDR_W     = 7;
  localparam int CMD_RW_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } state_e;

endpackage

// File: rtl/usb_spi_target_regs_sync.sv
// Brings the asynchronous SPI pins into the clk domain and derives single-cycle
// edge pulses for SCK and CS from the last synchronizer stage vs. a delayed copy.
module usb_spi_target_regs_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic spi_cs_b_i,
  input  logic spi_sck_i,
  input  logic spi_mosi_i,
  output logic cs_s_o,
  output logic mosi_s_o,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic cs_fall_o,
  output logic cs_rise_o
);

  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   cs_prev_q;
  logic                   sck_prev_q;

  // Synchronizer chains plus one extra stage for edge detection. Clearing CS to
  // 0 keeps a chip select held low through reset from looking like a new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync_q   <= '0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b0;
      sck_prev_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value,
      // which is exactly what turns this chain into a shift register.
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_b_i};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  assign cs_s_o     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s_o   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise_o =  sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
  assign sck_fall_o = ~sck_sync_q[SYNC_STAGES-1] &  sck_prev_q;
  assign cs_fall_o  = ~cs_sync_q[SYNC_STAGES-1]  &  cs_prev_q;
  assign cs_rise_o  =  cs_sync_q[SYNC_STAGES-1]  & ~cs_prev_q;

endmodule

// File: rtl/usb_spi_target_regs.sv
// SPI mode-0 target that maps an external SPI master onto a one-cycle-strobe
// register bus. Byte 0 is {rw, addr}; following bytes are written to, or read
// (with one-byte prefetch) from, auto-incrementing 7-bit addresses.
module usb_spi_target_regs
  import usb_spi_target_regs_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_BYTE     = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs_b,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [7:0]        bus_rdata,
  output logic              frame_abort
);

  logic cs_s, mosi_s, sck_rise, sck_fall, cs_fall, cs_rise;

  usb_spi_target_regs_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .spi_cs_b_i (spi_cs_b),
    .spi_sck_i  (spi_sck),
    .spi_mosi_i (spi_mosi),
    .cs_s_o     (cs_s),
    .mosi_s_o   (mosi_s),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .cs_fall_o  (cs_fall),
    .cs_rise_o  (cs_rise)
  );

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic [7:0]        tx_hold_q, tx_hold_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              armed_q, armed_d;
  logic              byte_done_q, byte_done_d;
  logic              load_pend_q, load_pend_d;
  logic              rd_pend_q, rd_pend_d;
  logic              oe_q, oe_d;
  logic              abort_q, abort_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [7:0]        bus_wdata_q, bus_wdata_d;
  logic              bus_we_q, bus_we_d;
  logic              bus_re_q, bus_re_d;

  // State register for the FSM, bit engine, address counter and bus strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      tx_hold_q   <= '0;
      addr_q      <= '0;
      armed_q     <= 1'b0;
      byte_done_q <= 1'b0;
      load_pend_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      oe_q        <= 1'b0;
      abort_q     <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_we_q    <= 1'b0;
      bus_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      tx_hold_q   <= tx_hold_d;
      addr_q      <= addr_d;
      armed_q     <= armed_d;
      byte_done_q <= byte_done_d;
      load_pend_q <= load_pend_d;
      rd_pend_q   <= rd_pend_d;
      oe_q        <= oe_d;
      abort_q     <= abort_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_we_q    <= bus_we_d;
      bus_re_q    <= bus_re_d;
    end
  end

  // Next-state logic: bit engine first, then FSM byte handling, then CS release
  // last so it overrides everything except strobes for an already-completed byte.
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that leaves
    // one unassigned would infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    tx_hold_d   = tx_hold_q;
    addr_d      = addr_q;
    armed_d     = armed_q | cs_s;
    byte_done_d = 1'b0;
    load_pend_d = load_pend_q;
    rd_pend_d   = bus_re_q;
    oe_d        = oe_q;
    abort_d     = 1'b0;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_we_d    = 1'b0;
    bus_re_d    = 1'b0;

    // Read data arrives one clk after the read strobe; park it for the next byte.
    if (rd_pend_q) tx_hold_d = bus_rdata;

    // The first SCK fall after a completed byte presents the held byte on MISO.
    if (byte_done_q) load_pend_d = 1'b1;

    if (state_q != ST_IDLE) begin
      if (sck_rise) begin
        rx_shift_d  = {rx_shift_q[6:0], mosi_s};
        bit_cnt_d   = bit_cnt_q + 3'd1;
        byte_done_d = (bit_cnt_q == 3'd7);
      end
      if (sck_fall) begin
        tx_shift_d  = load_pend_q ? tx_hold_q : {tx_shift_q[6:0], 1'b0};
        load_pend_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall && armed_q) begin
          state_d     = ST_CMD;
          tx_shift_d  = ID_BYTE;
          tx_hold_d   = 8'h00;
          bit_cnt_d   = '0;
          load_pend_d = 1'b0;
          oe_d        = 1'b1;
        end
      end
      ST_CMD: begin
        if (byte_done_q) begin
          addr_d = rx_shift_q[ADDR_W-1:0];
          if (rx_shift_q[CMD_RW_BIT]) begin
            state_d   = ST_WR;
            tx_hold_d = 8'h00;
          end else begin
            state_d    = ST_RD;
            bus_re_d   = 1'b1;
            bus_addr_d = rx_shift_q[ADDR_W-1:0];
          end
        end
      end
      ST_WR: begin
        if (byte_done_q) begin
          bus_we_d    = 1'b1;
          bus_addr_d  = addr_q;
          bus_wdata_d = rx_shift_q;
          addr_d      = addr_q + 7'd1;
        end
      end
      ST_RD: begin
        if (byte_done_q) begin
          bus_re_d   = 1'b1;
          bus_addr_d = addr_q + 7'd1;
          addr_d     = addr_q + 7'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // CS release ends the frame; a partially shifted byte is dropped and flagged.
    if (cs_rise) begin
      state_d     = ST_IDLE;
      oe_d        = 1'b0;
      tx_shift_d  = 8'h00;
      bit_cnt_d   = '0;
      byte_done_d = 1'b0;
      load_pend_d = 1'b0;
      abort_d     = (state_q != ST_IDLE) && (bit_cnt_q != 3'd0);
    end
  end

  assign spi_miso    = tx_shift_q[7];
  assign spi_miso_oe = oe_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_we      = bus_we_q;
  assign bus_re      = bus_re_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_usb_spi_target_regs.sv
// Directed bench: SPI mode-0 master BFM at f_clk/8, register model returning
// addr ^ 8'hF0 one clk after each read strobe, bus-event log checked per frame.
module tb_usb_spi_target_regs;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_cs_b, spi_sck, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [6:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we, bus_re;
  logic [7:0] bus_rdata;
  logic       frame_abort;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] we_addr [16];
  logic [7:0] we_data [16];
  logic [6:0] re_addr [16];
  int         we_cnt, re_cnt, abort_cnt, both_cnt;
  logic [7:0] miso_byte [8];
  logic       oe_mid;

  usb_spi_target_regs #(
    .SYNC_STAGES (2),
    .ID_BYTE     (8'hA5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_cs_b    (spi_cs_b),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_we      (bus_we),
    .bus_re      (bus_re),
    .bus_rdata   (bus_rdata),
    .frame_abort (frame_abort)
  );

  always #10 clk = ~clk;

  // Register model: read data valid exactly one clk after the read strobe.
  always @(posedge clk) begin
    if (bus_re) bus_rdata <= {1'b0, bus_addr} ^ 8'hF0;
  end

  // Bus monitor: log strobes and aborts as they happen.
  always @(posedge clk) begin
    if (!reset) begin
      if (bus_we && we_cnt < 16) begin
        we_addr[we_cnt] = bus_addr;
        we_data[we_cnt] = bus_wdata;
      end
      if (bus_we) we_cnt++;
      if (bus_re && re_cnt < 16) re_addr[re_cnt] = bus_addr;
      if (bus_re) re_cnt++;
      if (frame_abort) abort_cnt++;
      if (bus_we && bus_re) both_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    @(negedge clk);
    we_cnt = 0; re_cnt = 0; abort_cnt = 0; both_cnt = 0;
  endtask

  task automatic cs_low();
    spi_cs_b = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    spi_cs_b = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Shift n bits MSB first; MISO is sampled at the moment SCK rises.
  task automatic xfer_bits(input logic [7:0] val, input int n, output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = val[7-i];
      repeat (4) @(negedge clk);
      miso = {miso[6:0], spi_miso};
      if (i == 0) oe_mid = spi_miso_oe;
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3, input int n);
    logic [7:0] bytes [4];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    cs_low();
    for (int k = 0; k < n; k++) xfer_bits(bytes[k], 8, miso_byte[k]);
    cs_high();
  endtask

  initial begin
    logic [7:0] junk;
    reset = 1'b1; spi_cs_b = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    we_cnt = 0; re_cnt = 0; abort_cnt = 0; both_cnt = 0; oe_mid = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_miso", spi_miso, 0);
    check("rst_oe", spi_miso_oe, 0);
    check("rst_strobes", {bus_we, bus_re, frame_abort}, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_wdata, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // 1: write burst
    clear_log();
    frame(8'h85, 8'h12, 8'h34, 8'h00, 3);
    check("t1_we_cnt", we_cnt, 2);
    check("t1_we0", {we_addr[0], we_data[0]}, {7'h05, 8'h12});
    check("t1_we1", {we_addr[1], we_data[1]}, {7'h06, 8'h34});
    check("t1_re_cnt", re_cnt, 0);
    check("t1_abort", abort_cnt, 0);
    check("t1_miso", {miso_byte[0], miso_byte[1], miso_byte[2]}, 24'hA50000);

    // 2: read burst with prefetch
    clear_log();
    frame(8'h03, 8'h00, 8'h00, 8'h00, 3);
    check("t2_re_cnt", re_cnt, 3);
    check("t2_re_addr", {re_addr[0], re_addr[1], re_addr[2]}, {7'h03, 7'h04, 7'h05});
    check("t2_miso", {miso_byte[0], miso_byte[1], miso_byte[2]}, 24'hA5F3F4);
    check("t2_we_cnt", we_cnt, 0);
    check("t2_oe_mid", oe_mid, 1);
    check("t2_oe_after", spi_miso_oe, 0);

    // 3: address wrap
    clear_log();
    frame(8'hFF, 8'h11, 8'h22, 8'h33, 4);
    check("t3_we_cnt", we_cnt, 3);
    check("t3_we0", {we_addr[0], we_data[0]}, {7'h7F, 8'h11});
    check("t3_we1", {we_addr[1], we_data[1]}, {7'h00, 8'h22});
    check("t3_we2", {we_addr[2], we_data[2]}, {7'h01, 8'h33});

    // 4: abort after 5 bits, then a clean write
    clear_log();
    cs_low();
    xfer_bits(8'h81, 5, junk);
    cs_high();
    check("t4_abort", abort_cnt, 1);
    check("t4_we_cnt", we_cnt, 0);
    clear_log();
    frame(8'h81, 8'h55, 8'h00, 8'h00, 2);
    check("t4b_we", {we_cnt[3:0], we_addr[0], we_data[0]}, {4'd1, 7'h01, 8'h55});
    check("t4b_abort", abort_cnt, 0);

    // 5: reset mid-read with CS held low
    cs_low();
    xfer_bits(8'h03, 8, junk);
    xfer_bits(8'h00, 3, junk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_out", {spi_miso, spi_miso_oe, bus_we, bus_re, frame_abort}, 0);
    check("t5_rst_bus", {bus_addr, bus_wdata}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_log();
    xfer_bits(8'h85, 8, junk);
    xfer_bits(8'h77, 8, junk);
    repeat (6) @(negedge clk);
    check("t5_ignored", {we_cnt[3:0], re_cnt[3:0], abort_cnt[3:0]}, 0);
    check("t5_oe_low", spi_miso_oe, 0);
    cs_high();
    clear_log();
    frame(8'h85, 8'h66, 8'h00, 8'h00, 2);
    check("t5_next", {we_cnt[3:0], we_addr[0], we_data[0]}, {4'd1, 7'h05, 8'h66});
    check("t5_next_miso", miso_byte[0], 8'hA5);

    // 6: command-only read
    clear_log();
    frame(8'h10, 8'h00, 8'h00, 8'h00, 1);
    check("t6_re", {re_cnt[3:0], re_addr[0]}, {4'd1, 7'h10});
    check("t6_we_abort", {we_cnt[3:0], abort_cnt[3:0]}, 0);

    check("never_we_and_re", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
